// File: rtl/lcd_pkg.sv
// Shared constants for the LCD frame sequencer: FSM encodings, HD44780 init
// commands and per-row DDRAM base addresses.
package lcd_pkg;

    // IDLE wait req | LOAD latch step byte | ISSUE start pulse | WAIT ctrl done | DELAY settle | FINISH frame_done
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DELAY  = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    localparam int N_INIT = 4;
    localparam logic [7:0] INIT_CMD [0:N_INIT-1] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    localparam logic [7:0] ROW_BASE [0:3] = '{8'h00, 8'h40, 8'h14, 8'h54};
    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic [7:0] row_cmd(input logic [1:0] row);
        return LCD_CMD_SET_DDRAM | ROW_BASE[row];
    endfunction

endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// Byte/handshake link between the frame sequencer and the LCD controller.
interface lcd_frame_sequencer_if;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_start;
    logic       lcd_done;

    modport master (output lcd_data, output lcd_rs, output lcd_start, input lcd_done);
    modport slave  (input lcd_data, input lcd_rs, input lcd_start, output lcd_done);
endinterface

// File: rtl/lcd_frame_buffer.sv
// ROWS*COLS character store: synchronous write, combinational read, clears to spaces.
module lcd_frame_buffer
    import lcd_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_char,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_char
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en && ({1'b0, wr_addr} < DEPTH_X)) begin
            mem_d[wr_addr] = wr_char;
        end
    end

    assign rd_char = mem_q[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ASCII_SPACE;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Walks the init command list and the frame buffer row by row, handing each
// byte to the LCD controller with a start/done handshake and a settle delay.
module lcd_frame_sequencer
    import lcd_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int DLY_CYCLES   = 262143,
    parameter int AUTO_REFRESH = 0,
    parameter int ADDR_W       = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_char,
    input  logic              init_req,
    input  logic              refresh_req,
    output logic              busy,
    output logic              frame_done,
    lcd_frame_sequencer_if.master lcd
);

    localparam int DEPTH   = ROWS * COLS;
    localparam int N_STEPS = N_INIT + ROWS * (1 + COLS);
    localparam int STEP_W  = $clog2(N_STEPS);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int DLY_W   = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(N_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_FRAME = STEP_W'(N_INIT);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS);
    localparam logic [DLY_W-1:0]  DLY_LAST   = DLY_W'(DLY_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              init_ok_q, init_ok_d;
    logic [7:0]        data_q, data_d;
    logic              rs_q, rs_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_char;

    lcd_frame_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_char (wr_char),
        .rd_addr (rd_addr),
        .rd_char (rd_char)
    );

    // col_q == 0 selects the row address command, col_q == k the (k-1)th character.
    assign rd_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q) - ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        row_d     = row_q;
        col_d     = col_q;
        dly_d     = dly_q;
        init_ok_d = init_ok_q;
        data_d    = data_q;
        rs_d      = rs_q;

        case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_LOAD;
                    step_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else if (refresh_req && init_ok_q) begin
                    state_d = ST_LOAD;
                    step_d  = STEP_FRAME;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_ISSUE;
                if (step_q < STEP_FRAME) begin
                    data_d = INIT_CMD[step_q[1:0]];
                    rs_d   = 1'b0;
                end else if (col_q == '0) begin
                    data_d = row_cmd(2'(row_q));
                    rs_d   = 1'b0;
                end else begin
                    data_d = rd_char;
                    rs_d   = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (lcd.lcd_done) begin
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dly_q == DLY_LAST) begin
                    dly_d = '0;
                    if (step_q == STEP_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_LOAD;
                        step_d  = step_q + 1'b1;
                        if (step_q >= STEP_FRAME) begin
                            if (col_q == COL_LAST) begin
                                row_d = row_q + 1'b1;
                                col_d = '0;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    end
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_FINISH: begin
                init_ok_d = 1'b1;
                if (AUTO_REFRESH != 0) begin
                    state_d = ST_LOAD;
                    step_d  = STEP_FRAME;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            dly_q     <= '0;
            init_ok_q <= 1'b0;
            data_q    <= '0;
            rs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            row_q     <= row_d;
            col_q     <= col_d;
            dly_q     <= dly_d;
            init_ok_q <= init_ok_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
        end
    end

    assign lcd.lcd_data  = data_q;
    assign lcd.lcd_rs    = rs_q;
    assign lcd.lcd_start = (state_q == ST_ISSUE);
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = (state_q == ST_FINISH);

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench: two sequencer instances (2x16 manual, 4x20 auto-refresh)
// each answered by a small controller model that returns done 3 cycles after start.
module tb_lcd_frame_sequencer;
    import lcd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, wr_en_a, init_a, refr_a, busy_a, fdone_a;
    logic [4:0] wr_addr_a;
    logic [7:0] wr_char_a;
    logic       reset_b, wr_en_b, init_b, refr_b, busy_b, fdone_b;
    logic [6:0] wr_addr_b;
    logic [7:0] wr_char_b;

    lcd_frame_sequencer_if if_a ();
    lcd_frame_sequencer_if if_b ();

    lcd_frame_sequencer #(.COLS(16), .ROWS(2), .DLY_CYCLES(4), .AUTO_REFRESH(0)) dut_a (
        .clk(clk), .reset(reset_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_char(wr_char_a),
        .init_req(init_a), .refresh_req(refr_a), .busy(busy_a), .frame_done(fdone_a), .lcd(if_a));

    lcd_frame_sequencer #(.COLS(20), .ROWS(4), .DLY_CYCLES(2), .AUTO_REFRESH(1)) dut_b (
        .clk(clk), .reset(reset_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_char(wr_char_b),
        .init_req(init_b), .refresh_req(refr_b), .busy(busy_b), .frame_done(fdone_b), .lcd(if_b));

    int checks = 0;
    int errors = 0;
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int cnt_a = 0, cnt_b = 0, fd_a = 0, fd_b = 0, fd_b_snap = -1;

    always @(negedge clk) begin
        if_a.lcd_done = 1'b0;
        if (if_a.lcd_start) begin
            cnt_a = 3;
            qa.push_back({if_a.lcd_rs, if_a.lcd_data});
        end else if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) if_a.lcd_done = 1'b1;
        end
        if (fdone_a) fd_a++;
    end

    always @(negedge clk) begin
        if_b.lcd_done = 1'b0;
        if (if_b.lcd_start) begin
            cnt_b = 3;
            qb.push_back({if_b.lcd_rs, if_b.lcd_data});
        end else if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) if_b.lcd_done = 1'b1;
        end
        if (fdone_b) begin
            if (fd_b == 0) fd_b_snap = qb.size();
            fd_b++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_a(input logic [4:0] addr, input logic [7:0] ch);
        @(negedge clk);
        wr_en_a = 1'b1; wr_addr_a = addr; wr_char_a = ch;
        @(negedge clk);
        wr_en_a = 1'b0;
    endtask

    task automatic req_a(input logic ini, input logic refr);
        @(negedge clk);
        init_a = ini; refr_a = refr;
        @(negedge clk);
        init_a = 1'b0; refr_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (busy_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy_a, 0);
    endtask

    task automatic chk_spaces_a(input string tag, input int exp_chars);
        int bad = 0, nch = 0;
        foreach (qa[i]) begin
            if (qa[i][8]) begin
                nch++;
                if (qa[i][7:0] != 8'h20) bad++;
            end
        end
        chk({tag, "_bad"}, bad, 0);
        chk({tag, "_nchars"}, nch, exp_chars);
    endtask

    initial begin
        int n, sz, bad;
        logic seen;
        reset_a = 1'b1; wr_en_a = 1'b0; init_a = 1'b0; refr_a = 1'b0; wr_addr_a = '0; wr_char_a = '0;
        reset_b = 1'b1; wr_en_b = 1'b0; init_b = 1'b0; refr_b = 1'b0; wr_addr_b = '0; wr_char_b = '0;
        if_a.lcd_done = 1'b0; if_b.lcd_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_start", if_a.lcd_start, 0);
        chk("rst_data", if_a.lcd_data, 0);
        chk("rst_rs", if_a.lcd_rs, 0);
        chk("rst_fdone", fdone_a, 0);
        reset_a = 1'b0;

        // full init + blank frame
        qa.delete(); fd_a = 0;
        req_a(1'b1, 1'b0);
        wait_idle_a("t1_idle");
        chk("t1_count", qa.size(), 38);
        chk("t1_p0", qa[0], 9'h038);
        chk("t1_p1", qa[1], 9'h00C);
        chk("t1_p2", qa[2], 9'h001);
        chk("t1_p3", qa[3], 9'h006);
        chk("t1_p4", qa[4], 9'h080);
        chk("t1_p21", qa[21], 9'h0C0);
        chk_spaces_a("t1_chars", 32);
        chk("t1_fdone", fd_a, 1);

        // text refresh
        write_a(5'd0, 8'h48); write_a(5'd1, 8'h45); write_a(5'd2, 8'h4C);
        write_a(5'd3, 8'h4C); write_a(5'd4, 8'h4F); write_a(5'd31, 8'h5A);
        qa.delete();
        req_a(1'b0, 1'b1);
        wait_idle_a("t2_idle");
        chk("t2_count", qa.size(), 34);
        chk("t2_p0", qa[0], 9'h080);
        chk("t2_p1", qa[1], 9'h148);
        chk("t2_p2", qa[2], 9'h145);
        chk("t2_p3", qa[3], 9'h14C);
        chk("t2_p4", qa[4], 9'h14C);
        chk("t2_p5", qa[5], 9'h14F);
        chk("t2_p17", qa[17], 9'h0C0);
        chk("t2_p33", qa[33], 9'h15A);

        // write collides with the LOAD of address 5 (step 10)
        qa.delete();
        req_a(1'b0, 1'b1);
        n = 0;
        while (!(dut_a.state_q == ST_LOAD && dut_a.step_q == 10) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t4_load_seen", (n < 400), 1);
        wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_char_a = 8'h41;
        @(negedge clk);
        wr_en_a = 1'b0;
        wait_idle_a("t4_idle1");
        chk("t4_old_sent", qa[6], 9'h120);
        qa.delete();
        req_a(1'b0, 1'b1);
        wait_idle_a("t4_idle2");
        chk("t4_new_sent", qa[6], 9'h141);

        // refresh before any init is ignored; simultaneous requests pick init
        @(negedge clk); reset_a = 1'b1;
        @(negedge clk); reset_a = 1'b0;
        qa.delete();
        req_a(1'b0, 1'b1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy_a) seen = 1'b1;
        end
        chk("t3_no_busy", seen, 0);
        chk("t3_no_start", qa.size(), 0);
        req_a(1'b1, 1'b1);
        wait_idle_a("t3_idle");
        chk("t3_both_count", qa.size(), 38);
        chk("t3_both_p0", qa[0], 9'h038);

        // reset during WAIT of step 10 aborts and clears the buffer
        write_a(5'd0, 8'h51);
        qa.delete();
        req_a(1'b1, 1'b0);
        n = 0;
        while (!(dut_a.state_q == ST_WAIT && dut_a.step_q == 10) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wait_seen", (n < 400), 1);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        chk("t6_start", if_a.lcd_start, 0);
        chk("t6_busy", busy_a, 0);
        sz = qa.size();
        repeat (20) @(negedge clk);
        chk("t6_quiet", qa.size(), sz);
        qa.delete();
        req_a(1'b1, 1'b0);
        wait_idle_a("t6_idle");
        chk("t6_count", qa.size(), 38);
        chk("t6_p0", qa[0], 9'h038);
        chk_spaces_a("t6_chars", 32);

        // 4x20 with auto refresh
        reset_b = 1'b0;
        @(negedge clk);
        wr_en_b = 1'b1; wr_addr_b = 7'd100; wr_char_b = 8'h55;
        @(negedge clk);
        wr_en_b = 1'b0;
        qb.delete(); fd_b = 0; fd_b_snap = -1;
        init_b = 1'b1;
        @(negedge clk);
        init_b = 1'b0;
        n = 0;
        while (!(fd_b >= 1 && qb.size() >= 89) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_done_seen", (n < 3000), 1);
        reset_b = 1'b1;
        @(negedge clk);
        chk("t5_steps", fd_b_snap, 88);
        chk("t5_init0", qb[0], 9'h038);
        chk("t5_row0", qb[4], 9'h080);
        chk("t5_row1", qb[25], 9'h0C0);
        chk("t5_row2", qb[46], 9'h094);
        chk("t5_row3", qb[67], 9'h0D4);
        chk("t5_auto", qb[88], 9'h080);
        bad = 0;
        for (int i = 0; i < 88 && i < qb.size(); i++) begin
            if (qb[i][8] && qb[i][7:0] != 8'h20) bad++;
        end
        chk("t5_chars", bad, 0);
        chk("t5_busy_rst", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
